mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single memory port between the multicycle CPU (master 0) and a second bus master such as a DMA or display fetch unit (master 1). It sits between the masters and the memory, accepts one transaction at a time, drives the memory read/write strobes and address, and returns read data plus a completion pulse to the winning master. Arbitration is round-robin. A timeout aborts accesses that the memory never acknowledges.

## Interface
- TIMEOUT, 15: maximum cycles spent in ACCESS waiting for `mem_ready` before the access is aborted; legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  master requests an access; held high until that master sees its done pulse.
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr / m1_addr  in  32  byte address; stable while req is high.
- m0_wdata / m1_wdata  in  32  write data; stable while req is high.
- m0_gnt / m1_gnt  out  1  master owns the memory port.
- m0_rdata / m1_rdata  out  32  read data, registered.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  valid with done; 1 = access timed out.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid when mem_ready = 1.
- mem_ready  in  1  memory acknowledge for the current strobe.

## Operation
- The block has three states:
  - IDLE: no master owns the port.
  - ACCESS: a memory access is in progress.
  - DONE: the completion cycle.
- Reset values (asynchronous, while `rst` = 0):
  - state = IDLE; `last` = 1.
  - All gnt, done, err, mem_read and mem_write outputs = 0.
  - mem_addr, mem_wdata, m0_rdata and m1_rdata = 0; timeout counter = 0.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that master wins.
  - Both requesting: the master not equal to `last` wins.
  - On a win: latch the winner's addr, we and wdata into mem_addr, mem_wdata and an internal we flag; set `last` to the winner; clear the counter; go to ACCESS.
- ACCESS:
  - Winner's gnt = 1.
  - mem_read = !we and mem_write = we; address and data are held constant.
  - Counter increments every cycle.
  - If mem_ready = 1 at an edge: for a read, capture mem_rdata into the winner's rdata; go to DONE with err = 0.
  - Otherwise, if the counter has reached TIMEOUT-1: go to DONE with err = 1; rdata is not updated.
  - If mem_ready and the timeout occur at the same edge, mem_ready wins (err = 0).
- DONE:
  - Winner's done = 1, winner's gnt stays 1, and err as decided in ACCESS.
  - mem_read = mem_write = 0.
  - Next state is unconditionally IDLE.
- Writes never modify rdata. Each rdata holds its value until that master's next successful read.
- A master must drop req at the edge that ends its DONE cycle. If req is still high in IDLE, it is treated as a new request.
- Requests from the losing master are neither lost nor latched; that master keeps req high and is served next.
- Masters must keep addr, we and wdata stable while req is high. The block captures them only in IDLE.
- Reset mid-transaction aborts the access immediately: strobes drop asynchronously and no done pulse is generated.

## Timing
- Request sampled at edge k (IDLE) -> gnt and mem strobe high from cycle k+1.
- mem_ready sampled high at edge j -> done and rdata valid in cycle j+1; strobes low in cycle j+1; IDLE in cycle j+2.
- Minimum transaction, with mem_ready high in the first ACCESS cycle: 3 cycles from request sample to IDLE. The earliest re-grant is sampled at the fourth edge.
- Timeout: a strobe held for TIMEOUT cycles without ready -> done with err in the following cycle.
- Under continuous contention, grants alternate m0, m1, m0, and so on. Neither master waits more than one transaction of the other.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single read: m0 reads 0x0000_0010; memory returns 0x1234_5678 with ready in the first ACCESS cycle.
  - mem_read high for exactly 1 cycle, then m0_done in the next cycle with m0_rdata = 0x1234_5678 and m0_err = 0.
- Simultaneous requests after reset: m0 and m1 both request.
  - m0 is granted first (last = 1).
  - Keeping both requesting for 4 transactions yields grant order m0, m1, m0, m1.
- Write with latency: m1 writes 0xDEAD_BEEF to 0x100; ready arrives after 3 cycles.
  - mem_write high for 3 cycles with mem_addr = 0x100 and mem_wdata = 0xDEAD_BEEF.
  - m1_done pulses; m1_rdata is unchanged.
- Timeout: TIMEOUT = 15 and mem_ready tied low on an m0 read.
  - mem_read high for 15 cycles, then m0_done = 1 and m0_err = 1; m0_rdata keeps its old value.
- Ready on the timeout edge: ready arrives exactly on the 15th ACCESS cycle.
  - err = 0 and data is captured.
- Reset mid-access: assert rst low during ACCESS.
  - mem_read drops without waiting for a clock edge and no done pulse is generated.
  - After release, m0 and m1 requesting together again gives m0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one memory port between two
// masters, aborting accesses the memory never acknowledges after TIMEOUT cycles.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        pick;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        pick     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // Under contention the master that did not win last time goes.
                    pick    = (m0_req && m1_req) ? ~last_q : m1_req;
                    win_d   = pick;
                    last_d  = pick;
                    we_d    = pick ? m1_we : m0_we;
                    addr_d  = pick ? m1_addr : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    cnt_d   = 8'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready) begin
                    if (!we_q && !win_q) rdata0_d = mem_rdata;
                    if (!we_q && win_q) rdata1_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_gnt    = (state_q != IDLE) && !win_q;
    assign m1_gnt    = (state_q != IDLE) && win_q;
    assign m0_done   = (state_q == DONE) && !win_q;
    assign m1_done   = (state_q == DONE) && win_q;
    assign m0_err    = m0_done && err_q;
    assign m1_err    = m1_done && err_q;
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, round-robin and reset sequences, plus random
// transactions checked against a transaction-level arbiter model.
module tb_mem_arbiter;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          nvec = 0;
    int          nerr = 0;
    bit          model_last;
    logic [31:0] model_rd [2];
    int          rr_n, rr_cyc, rr_w;
    bit          seen_done;

    typedef struct {
        bit          r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int          lat;
        logic [31:0] rdat;
        int          win;
        bit          err;
        int          strb;
    } vec_t;

    vec_t tbl [8];
    vec_t rv;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .m1_done(m1_done), .m1_err(m1_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk(nm, {26'd0, m0_gnt, m1_gnt, m0_done, m1_done, mem_read, mem_write},
            32'd0);
    endtask

    // Runs one transaction; the memory answers on strobe cycle v.lat (0 = never).
    task automatic apply_txn(input vec_t v, input string tag);
        int          strb = 0;
        int          act_win = 2;
        int          done_m = 2;
        int          cyc = 0;
        bit          got_done = 1'b0;
        bit          act_err = 1'b0;
        logic [31:0] a_addr = '0, a_wdata = '0, rd0 = '0, rd1 = '0;
        logic        a_wr = 1'b0;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
        e_addr  = (v.win == 1) ? v.a1 : v.a0;
        e_wdata = (v.win == 1) ? v.d1 : v.d0;
        e_we    = (v.win == 1) ? v.we1 : v.we0;
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_read || mem_write) begin
                strb++;
                if (strb == 1) begin
                    act_win = m1_gnt ? 1 : (m0_gnt ? 0 : 2);
                    a_addr  = mem_addr;
                    a_wdata = mem_wdata;
                    a_wr    = mem_write;
                end
                mem_ready = (strb == v.lat);
                mem_rdata = (strb == v.lat) ? v.rdat : $urandom;
            end else begin
                mem_ready = 1'b0;
            end
            if (m0_done || m1_done) begin
                got_done = 1'b1;
                done_m   = m1_done ? 1 : 0;
                act_err  = m1_done ? m1_err : m0_err;
                rd0      = m0_rdata;
                rd1      = m1_rdata;
                m0_req   = 1'b0;
                m1_req   = 1'b0;
            end
        end
        mem_ready = 1'b0;
        m0_req    = 1'b0;
        m1_req    = 1'b0;
        if (!v.err && !e_we) model_rd[v.win] = v.rdat;
        model_last = (v.win == 1);
        chk({tag, ".done"}, 32'(got_done), 32'd1);
        chk({tag, ".win"}, act_win, v.win);
        chk({tag, ".donem"}, done_m, v.win);
        chk({tag, ".strobes"}, strb, v.strb);
        chk({tag, ".err"}, 32'(act_err), 32'(v.err));
        chk({tag, ".addr"}, a_addr, e_addr);
        chk({tag, ".we"}, 32'(a_wr), 32'(e_we));
        if (e_we) chk({tag, ".wdata"}, a_wdata, e_wdata);
        chk({tag, ".rdata0"}, rd0, model_rd[0]);
        chk({tag, ".rdata1"}, rd1, model_rd[1]);
        @(negedge clk);
        chk_idle({tag, ".idle"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // fields: r0 r1 we0 we1 a0 a1 d0 d1 lat rdat win err strb
        tbl[0] = '{1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0,
                   1, 32'h1234_5678, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 1, 32'h0, 32'h100, 32'h0, 32'hDEAD_BEEF,
                   3, 32'h5555_5555, 1, 0, 3};
        tbl[2] = '{1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0,
                   0, 32'h0BAD_0BAD, 0, 1, 15};
        tbl[3] = '{1, 0, 0, 0, 32'h30, 32'h0, 32'h0, 32'h0,
                   15, 32'hCAFE_F00D, 0, 0, 15};
        tbl[4] = '{1, 1, 0, 0, 32'h40, 32'h44, 32'h0, 32'h0,
                   2, 32'hA5A5_0001, 1, 0, 2};
        tbl[5] = '{1, 1, 0, 0, 32'h48, 32'h4C, 32'h0, 32'h0,
                   16, 32'h7777_7777, 0, 1, 15};
        tbl[6] = '{0, 1, 0, 0, 32'h0, 32'h50, 32'h0, 32'h0,
                   1, 32'h1111_2222, 1, 0, 1};
        tbl[7] = '{1, 1, 1, 0, 32'h60, 32'h64, 32'h0F0F_0F0F, 32'h0,
                   4, 32'h9999_9999, 0, 0, 4};

        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk_idle("reset.ctrl");
        chk("reset.err", {30'd0, m0_err, m1_err}, 32'd0);
        chk("reset.addr", mem_addr, 32'd0);
        chk("reset.wdata", mem_wdata, 32'd0);
        chk("reset.rdata0", m0_rdata, 32'd0);
        chk("reset.rdata1", m1_rdata, 32'd0);
        rst = 1'b1;
        model_last  = 1'b1;
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;

        // Both masters hold req continuously: grants must alternate from m0.
        m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h204;
        rr_n = 0;
        rr_cyc = 0;
        while (rr_n < 4 && rr_cyc < 60) begin
            @(negedge clk);
            rr_cyc++;
            mem_ready = mem_read || mem_write;
            mem_rdata = 32'hC0DE_0000 + 32'(rr_n);
            if (m0_done || m1_done) begin
                rr_w = m1_done ? 1 : 0;
                chk($sformatf("rr.order%0d", rr_n), rr_w, rr_n % 2);
                model_rd[rr_w] = 32'hC0DE_0000 + 32'(rr_n);
                model_last = (rr_w == 1);
                chk($sformatf("rr.rdata%0d", rr_n),
                    (rr_w == 1) ? m1_rdata : m0_rdata, model_rd[rr_w]);
                rr_n++;
                if (rr_n == 4) begin
                    m0_req = 0;
                    m1_req = 0;
                end
            end
        end
        mem_ready = 0;
        chk("rr.count", rr_n, 4);
        @(negedge clk);
        chk_idle("rr.idle");

        for (int i = 0; i < 8; i++) apply_txn(tbl[i], $sformatf("tbl%0d", i));

        for (int k = 0; k < 40; k++) begin
            int pat;
            pat    = $urandom_range(1, 3);
            rv.r0  = pat[0];
            rv.r1  = pat[1];
            rv.we0 = 1'($urandom);
            rv.we1 = 1'($urandom);
            rv.a0  = $urandom;
            rv.a1  = $urandom;
            rv.d0  = $urandom;
            rv.d1  = $urandom;
            rv.lat = $urandom_range(0, TO + 2);
            rv.rdat = $urandom;
            if (rv.r0 && rv.r1) rv.win = model_last ? 0 : 1;
            else rv.win = rv.r1 ? 1 : 0;
            rv.err  = (rv.lat == 0) || (rv.lat > TO);
            rv.strb = rv.err ? TO : rv.lat;
            apply_txn(rv, $sformatf("rnd%0d", k));
        end

        // Reset in the middle of an access.
        m0_req = 1; m0_we = 0; m0_addr = 32'h300; mem_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst.strobe_before", 32'(mem_read), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst.async_read", 32'(mem_read), 32'd0);
        chk("rst.async_gnt", 32'(m0_gnt), 32'd0);
        m0_req = 0;
        @(negedge clk);
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_done || m1_done) seen_done = 1'b1;
        end
        chk("rst.nodone", 32'(seen_done), 32'd0);
        chk("rst.rdata0", m0_rdata, 32'd0);
        model_last  = 1'b1;
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;
        rv = '{1, 1, 0, 0, 32'h400, 32'h404, 32'h0, 32'h0,
               1, 32'h4242_4242, 0, 0, 1};
        apply_txn(rv, "rst.after");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
